// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial controller: state encodings and
// default sizing of the iteration watchdog.
package factorial_pkg;

   localparam int unsigned MAX_ITER_DEF = 255;
   localparam int unsigned CNT_W_DEF    = 8;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      INIT_I  = 4'd1,
      INIT_FI = 4'd2,
      CHECK   = 4'd3,
      INC_I   = 4'd4,
      MUL_FI  = 4'd5,
      LOAD_O  = 4'd6,
      DONE    = 4'd7,
      ERR     = 4'd8
   } state_t;

endpackage

// File: rtl/factorial_iter_counter.sv
// Saturating iteration counter used as the controller watchdog.
// Clear has priority over increment; the count never wraps past MAX_ITER.
module iter_counter
   import factorial_pkg::*;
#(
   parameter int unsigned MAX_ITER = MAX_ITER_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic at_max
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX_CNT)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign at_max = (cnt == MAX_CNT);

endmodule

// File: rtl/factorial_ctrl.sv
// Moore control FSM for the factorial datapath with start/busy/done/err
// handshake and an iteration watchdog that aborts runaway loops.
module factorial_ctrl
   import factorial_pkg::*;
#(
   parameter int unsigned MAX_ITER = MAX_ITER_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic start,
   input  logic i_lt_x,
   output logic ld_i,
   output logic ld_fi,
   output logic ld_o,
   output logic st,
   output logic busy,
   output logic done,
   output logic err
);

   state_t state;
   state_t state_nxt;
   logic   at_max;

   iter_counter #(
      .MAX_ITER (MAX_ITER),
      .CNT_W    (CNT_W)
   ) u_iter_counter (
      .clk    (CLK),
      .rst_n  (RST),
      .clr    (state == INIT_I),
      .inc    (state == INC_I),
      .at_max (at_max)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = start ? INIT_I : IDLE;
         INIT_I:  state_nxt = INIT_FI;
         INIT_FI: state_nxt = CHECK;
         CHECK: begin
            if (!i_lt_x) begin
               state_nxt = LOAD_O;
            end else if (at_max) begin
               state_nxt = ERR;
            end else begin
               state_nxt = INC_I;
            end
         end
         INC_I:   state_nxt = MUL_FI;
         MUL_FI:  state_nxt = CHECK;
         LOAD_O:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Illegal encodings decode like IDLE so outputs stay safe for the one cycle
   // before the register recovers.
   always_comb begin
      ld_i  = 1'b0;
      ld_fi = 1'b0;
      ld_o  = 1'b0;
      st    = 1'b0;
      busy  = 1'b1;
      done  = 1'b0;
      err   = 1'b0;
      case (state)
         IDLE: begin
            st   = 1'b1;
            busy = 1'b0;
         end
         INIT_I: begin
            ld_i = 1'b1;
            st   = 1'b1;
         end
         INIT_FI: begin
            ld_fi = 1'b1;
            st    = 1'b1;
         end
         CHECK:   ;
         INC_I:   ld_i  = 1'b1;
         MUL_FI:  ld_fi = 1'b1;
         LOAD_O:  ld_o  = 1'b1;
         DONE:    done  = 1'b1;
         ERR:     err   = 1'b1;
         default: begin
            st   = 1'b1;
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_factorial_ctrl.sv
// Directed bench for factorial_ctrl driving a small behavioural datapath model;
// watchdog shrunk to MAX_ITER=4 so the abort path is reachable quickly.
module tb_factorial_ctrl;

   logic       CLK;
   logic       RST;
   logic       start;
   logic       i_lt_x;
   logic       ld_i, ld_fi, ld_o, st, busy, done, err;

   logic [7:0] x;
   logic       force_lt;
   logic [7:0] i_r, fi_r, fi_out;

   int n_cmp;
   int n_bad;

   factorial_ctrl #(
      .MAX_ITER (4),
      .CNT_W    (3)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .start  (start),
      .i_lt_x (i_lt_x),
      .ld_i   (ld_i),
      .ld_fi  (ld_fi),
      .ld_o   (ld_o),
      .st     (st),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Datapath model: i, fi registers with st-selected init/iterate, output reg.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         i_r  <= 8'd0;
         fi_r <= 8'd0;
      end else begin
         if (ld_i)  i_r  <= st ? 8'd1 : i_r + 8'd1;
         if (ld_fi) fi_r <= st ? 8'd1 : fi_r * i_r;
      end
   end

   always @(posedge CLK) begin
      if (RST && ld_o) fi_out <= fi_r;
   end

   assign i_lt_x = force_lt | (i_r < x);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Every-cycle invariant: at most one load, st high whenever idle, st low
   // in LOAD_O/DONE/ERR.
   always @(negedge CLK) begin
      if (RST === 1'b1) begin
         chk("invariant",
             {29'd0, (int'(ld_i) + int'(ld_fi) + int'(ld_o)) > 1,
              (!busy && !st), ((ld_o | done | err) && st)}, 32'd0);
      end
   end

   // Outputs packed as {ld_i, ld_fi, ld_o, st, busy, done, err}.
   localparam logic [6:0] IDLE_OUT = 7'b0001000;

   task automatic run(input logic [7:0] xv, input bit frc, input int e, input bit e_err,
                      input logic [7:0] e_fi, input int pulse_at, input bit hold,
                      input bit chained);
      int         lc;
      logic [6:0] want;
      x        = xv;
      force_lt = frc;
      if (!chained) begin
         @(negedge CLK);
         chk($sformatf("x%0d_pre_idle", xv), {ld_i, ld_fi, ld_o, st, busy, done, err}, IDLE_OUT);
         start = 1'b1;
      end
      lc = e_err ? e - 1 : e - 2;
      for (int c = 1; c <= e; c++) begin
         @(negedge CLK);
         start = hold || (c == pulse_at);
         want[6] = (c == 1) || (c >= 3 && c <= lc && (c - 3) % 3 == 1);
         want[5] = (c == 2) || (c >= 3 && c <= lc && (c - 3) % 3 == 2);
         want[4] = !e_err && (c == e - 1);
         want[3] = (c <= 2);
         want[2] = 1'b1;
         want[1] = !e_err && (c == e);
         want[0] = e_err && (c == e);
         chk($sformatf("x%0d_cyc%0d", xv, c), {ld_i, ld_fi, ld_o, st, busy, done, err}, want);
      end
      chk($sformatf("x%0d_fi_out", xv), fi_out, e_fi);
      @(negedge CLK);
      start = hold;
      chk($sformatf("x%0d_post_idle", xv), {ld_i, ld_fi, ld_o, st, busy, done, err}, IDLE_OUT);
      force_lt = 1'b0;
   endtask

   typedef struct {
      logic [7:0] x;
      bit         frc;
      int         cyc;
      bit         is_err;
      logic [7:0] fi;
   } vec_t;

   vec_t vecs[9];

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      RST      = 1'b0;
      start    = 1'b0;
      x        = 8'd0;
      force_lt = 1'b0;
      fi_out   = 8'd0;

      #1;
      chk("reset_outputs", {ld_i, ld_fi, ld_o, st, busy, done, err}, IDLE_OUT);
      @(negedge CLK);
      RST = 1'b1;

      // X=6 needs a 5th INC_I with MAX_ITER=4, so it aborts and fi_out keeps 120.
      vecs[0] = '{8'd0, 1'b0,  5, 1'b0, 8'd1};
      vecs[1] = '{8'd1, 1'b0,  5, 1'b0, 8'd1};
      vecs[2] = '{8'd2, 1'b0,  8, 1'b0, 8'd2};
      vecs[3] = '{8'd3, 1'b0, 11, 1'b0, 8'd6};
      vecs[4] = '{8'd4, 1'b0, 14, 1'b0, 8'd24};
      vecs[5] = '{8'd5, 1'b0, 17, 1'b0, 8'h78};
      vecs[6] = '{8'd6, 1'b0, 16, 1'b1, 8'h78};
      vecs[7] = '{8'd3, 1'b0, 11, 1'b0, 8'd6};
      vecs[8] = '{8'd0, 1'b1, 16, 1'b1, 8'd6};

      for (int k = 0; k < 9; k++) begin
         run(vecs[k].x, vecs[k].frc, vecs[k].cyc, vecs[k].is_err, vecs[k].fi, 0, 1'b0, 1'b0);
      end

      // start pulses while busy (mid-loop and in DONE) are ignored.
      run(8'd3, 1'b0, 11, 1'b0, 8'd6, 4, 1'b0, 1'b0);
      run(8'd2, 1'b0, 8, 1'b0, 8'd2, 8, 1'b0, 1'b0);

      // start held high: one IDLE cycle, then the next run begins.
      run(8'd4, 1'b0, 14, 1'b0, 8'd24, 0, 1'b1, 1'b0);
      run(8'd3, 1'b0, 11, 1'b0, 8'd6, 0, 1'b0, 1'b1);

      // Asynchronous reset in INC_I.
      x = 8'd5;
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (3) @(negedge CLK);
      chk("pre_reset_inc_i", {ld_i, ld_fi, ld_o, st, busy, done, err}, 7'b1000100);
      #2 RST = 1'b0;
      #1;
      chk("async_reset_now", {ld_i, ld_fi, ld_o, st, busy, done, err}, IDLE_OUT);
      @(negedge CLK);
      chk("reset_held", {ld_i, ld_fi, ld_o, st, busy, done, err}, IDLE_OUT);
      RST = 1'b1;
      @(negedge CLK);
      chk("after_reset_idle", {ld_i, ld_fi, ld_o, st, busy, done, err}, IDLE_OUT);
      run(8'd5, 1'b0, 17, 1'b0, 8'h78, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/factorial_ctrl.md
Name: factorial_ctrl

Overview:
- Control FSM for the factorial datapath. It drives ld_i, ld_fi, ld_o and st, and observes i_lt_x.
- Implements: i=1, fi=1; while (i < X) { i=i+1; fi=fi*i; }; fi_out=fi.
- Sits beside `datapath` in the top-level `factorial` wrapper and exposes a start/busy/done/err handshake to the host.
- Includes an iteration watchdog so a stuck or miswired comparator cannot hang the block.

Parameters:
- MAX_ITER, 255: maximum number of INC_I visits per run before the run aborts with err.
- CNT_W, 8: width of the iteration counter. Must satisfy 2^CNT_W > MAX_ITER.

Ports:
- CLK  in  1  rising-edge clock shared with the datapath.
- RST  in  1  asynchronous, active-low reset. RST=0 forces reset immediately.
- start  in  1  run request, sampled only in IDLE.
- i_lt_x  in  1  datapath comparator (i < X), combinational from the datapath registers.
- ld_i  out  1  datapath i-register load enable.
- ld_fi  out  1  datapath fi-register load enable.
- ld_o  out  1  datapath output-register load enable.
- st  out  1  datapath mux select: 1 = initial values (i=1, fi=1), 0 = iterate (i+1, fi*i).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: fi_out is valid and the run completed normally.
- err  out  1  one-cycle pulse: the run aborted because the watchdog expired.

Behaviour:
- Moore FSM. Outputs are decoded only from the registered state, never from inputs. The datapath acts on the CLK edge that ends each state.
- Reset (RST low, asynchronous):
  - state = IDLE, iteration counter = 0.
  - ld_i = ld_fi = ld_o = 0, st = 1, busy = done = err = 0.
  - The same values hold while RST is low.
  - Reset mid-run abandons the run. The datapath register contents are don't-care until the next INIT.
- States, outputs and transitions:
  - IDLE: st=1. If start=1, go to INIT_I; otherwise stay.
  - INIT_I: ld_i=1, st=1, clear the counter. Go to INIT_FI.
  - INIT_FI: ld_fi=1, st=1. Go to CHECK.
  - CHECK: st=0, no loads. Evaluates i_lt_x:
    - i_lt_x=0: go to LOAD_O.
    - i_lt_x=1 and counter==MAX_ITER: go to ERR.
    - i_lt_x=1 otherwise: go to INC_I.
  - INC_I: ld_i=1, st=0, counter += 1. Go to MUL_FI.
  - MUL_FI: ld_fi=1, st=0. Go to CHECK.
  - LOAD_O: ld_o=1, st=0. Go to DONE.
  - DONE: done=1. Go to IDLE.
  - ERR: err=1, no loads, so fi_out keeps its previous value. Go to IDLE.
- Only one ld_* is high in any cycle. ld_* are never high in IDLE, CHECK, DONE or ERR.
- Latency:
  - From the edge that samples start to the done cycle: 5 + 3*(N-1) cycles, where N = max(X,1).
  - X=0 and X=1 both take 5 cycles.
- start behaviour:
  - Ignored while busy=1.
  - If start is still high when the FSM returns to IDLE, the next run begins on the following edge. There are no stuck states.
- Arithmetic: the counter saturates at MAX_ITER and never wraps. The 8-bit overflow of fi*i is a datapath matter; the controller ignores it.
- Undefined or illegal state encodings go to IDLE on the next edge.

Decomposition:
- Shared package `factorial_pkg`: state encodings (IDLE, INIT_I, INIT_FI, CHECK, INC_I, MUL_FI, LOAD_O, DONE, ERR) as 4-bit localparams, and the MAX_ITER default.
- Sub-module `iter_counter`: synchronous clear and increment, saturating at MAX_ITER, asynchronous active-low reset, outputs `at_max`.
- The top-level `factorial` module instantiates `factorial_ctrl` and `datapath`.

Test Plan:
- Reset: assert RST=0 mid-run (in INC_I) -> outputs go to ld_*=0, st=1, busy=0 within the same cycle, with no clock needed; after release, state is IDLE.
- Normal run, X=3 (controller + datapath): start pulse -> the ld sequence is i, fi, (i, fi)x2, o; done rises 11 cycles after start is sampled; fi_out=6; busy is high for exactly 11 cycles.
- Boundary inputs:
  - X=0 -> done after 5 cycles, fi_out=1.
  - X=1 -> done after 5 cycles, fi_out=1.
  - X=5 -> fi_out=120 (120 = 0x78), done after 17 cycles.
- Watchdog: controller alone, MAX_ITER=4, i_lt_x tied to 1 -> exactly 4 INC_I/MUL_FI pairs, then err is a one-cycle pulse, done never rises, ld_o never rises, FSM returns to IDLE.
- Handshake:
  - Pulse start again during busy -> ignored; the run length is unchanged.
  - Hold start high continuously -> back-to-back runs, with each done followed by one IDLE cycle and then INIT_I.
- Invariant, checked every cycle in all tests: at most one ld_* is high, and st=1 exactly in IDLE, INIT_I and INIT_FI.
